// File: rtl/ingress_filter_if.sv
// Ingress packet / port-FIFO write bus for one ingress_filter port.
// master drives packets and FIFO status; slave is the filter.
interface ingress_filter_if #(
    parameter int PACKET_WIDTH = 16
) ();
    logic                    valid_in;
    logic [PACKET_WIDTH-1:0] pkt_in;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [PACKET_WIDTH-1:0] fifo_wr_data;

    modport master (
        output valid_in,
        output pkt_in,
        output fifo_full,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

    modport slave (
        input  valid_in,
        input  pkt_in,
        input  fifo_full,
        output fifo_wr_en,
        output fifo_wr_data
    );
endinterface

// File: rtl/ingress_filter.sv
// Per-port ingress filter: registers packets, checks headers, feeds the
// port FIFO, keeps saturating stats and quarantines noisy ports.
module ingress_filter #(
    parameter int PACKET_WIDTH = 16,
    parameter int PORT_ID      = 0,
    parameter int CNT_WIDTH    = 16,
    parameter int ERR_LIMIT    = 4,
    parameter int BLOCK_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ingress_filter_if.slave      bus,
    input  logic                 clear_cnt,
    output logic [CNT_WIDTH-1:0] acc_cnt,
    output logic [CNT_WIDTH-1:0] drop_full_cnt,
    output logic [CNT_WIDTH-1:0] drop_full_dest_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] drop_blk_cnt,
    output logic                 blocked
);

    localparam int ERW = (ERR_LIMIT < 1) ? 1 : $clog2(ERR_LIMIT + 1);
    localparam int TW  = $clog2(BLOCK_CYCLES + 1);

    localparam logic [3:0]           SRC_ID   = 4'(PORT_ID);
    localparam logic [3:0]           SELF_BIT = 4'(1 << PORT_ID);
    localparam logic [ERW-1:0]       ERR_MAX  = ERW'(ERR_LIMIT);
    localparam logic [TW-1:0]        BLK_LOAD = TW'(BLOCK_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic {
        PASS,
        BLOCK
    } state_t;

    state_t                  state, state_d;
    logic [TW-1:0]           timer, timer_d;
    logic [ERW-1:0]          err_run, err_run_d, err_inc;

    logic                    stage_valid;
    logic [PACKET_WIDTH-1:0] stage_pkt;

    logic [3:0]              src;
    logic [3:0]              tgt;
    logic [1:0]              typ;
    logic                    malformed;
    logic [2:0]              tgt_pop;
    logic [CNT_WIDTH:0]      dest_sum;

    logic                    cls_blk;
    logic                    cls_err;
    logic                    cls_full;
    logic                    cls_acc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v
    );
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_pkt   <= '0;
        end else begin
            stage_valid <= bus.valid_in;
            stage_pkt   <= bus.pkt_in;
        end
    end

    assign src = stage_pkt[3:0];
    assign tgt = stage_pkt[7:4];
    assign typ = stage_pkt[9:8];

    assign malformed = (src != SRC_ID)
                     | (tgt == 4'd0)
                     | (|(tgt & SELF_BIT))
                     | (typ == 2'b11);

    assign tgt_pop = 3'(tgt[0]) + 3'(tgt[1])
                   + 3'(tgt[2]) + 3'(tgt[3]);

    assign dest_sum = {1'b0, drop_full_dest_cnt}
                    + (CNT_WIDTH + 1)'(tgt_pop);

    // Exclusive classification: BLOCK beats malformed beats full.
    assign cls_blk  = stage_valid & (state == BLOCK);
    assign cls_err  = stage_valid & (state == PASS) & malformed;
    assign cls_full = stage_valid & (state == PASS) & ~malformed
                    & bus.fifo_full;
    assign cls_acc  = stage_valid & (state == PASS) & ~malformed
                    & ~bus.fifo_full;

    assign bus.fifo_wr_en   = cls_acc;
    assign bus.fifo_wr_data = stage_valid ? stage_pkt : '0;
    assign blocked          = (state == BLOCK);

    assign err_inc = (err_run == '1) ? err_run : err_run + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PASS;
            timer   <= '0;
            err_run <= '0;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            err_run <= err_run_d;
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = timer;
        err_run_d = err_run;
        unique case (state)
            PASS: begin
                if (stage_valid) begin
                    if (!malformed) begin
                        err_run_d = '0;
                    end else if (ERR_LIMIT != 0 && err_inc == ERR_MAX) begin
                        state_d   = BLOCK;
                        timer_d   = BLK_LOAD;
                        err_run_d = '0;
                    end else begin
                        err_run_d = err_inc;
                    end
                end
            end
            BLOCK: begin
                timer_d = timer - 1'b1;
                if (timer == TW'(1)) begin
                    state_d = PASS;
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt            <= '0;
            drop_full_cnt      <= '0;
            drop_full_dest_cnt <= '0;
            err_cnt            <= '0;
            drop_blk_cnt       <= '0;
        end else if (clear_cnt) begin
            acc_cnt            <= '0;
            drop_full_cnt      <= '0;
            drop_full_dest_cnt <= '0;
            err_cnt            <= '0;
            drop_blk_cnt       <= '0;
        end else if (cls_blk) begin
            drop_blk_cnt <= sat_inc(drop_blk_cnt);
        end else if (cls_err) begin
            err_cnt <= sat_inc(err_cnt);
        end else if (cls_full) begin
            drop_full_cnt      <= sat_inc(drop_full_cnt);
            drop_full_dest_cnt <= dest_sum[CNT_WIDTH]
                                ? CNT_MAX
                                : dest_sum[CNT_WIDTH-1:0];
        end else if (cls_acc) begin
            acc_cnt <= sat_inc(acc_cnt);
        end
    end

endmodule

// File: tb/tb_ingress_filter.sv
// Directed bench for ingress_filter (PORT_ID=1, 4-bit counters).
// Inputs change on negedge; outputs are sampled on negedge.
module tb_ingress_filter;

    localparam int PW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_cnt;
    logic [CW-1:0] acc_cnt;
    logic [CW-1:0] drop_full_cnt;
    logic [CW-1:0] drop_full_dest_cnt;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] drop_blk_cnt;
    logic          blocked;

    int n_pass  = 0;
    int n_total = 0;

    ingress_filter_if #(.PACKET_WIDTH(PW)) bus ();

    ingress_filter #(
        .PACKET_WIDTH(PW),
        .PORT_ID     (1),
        .CNT_WIDTH   (CW),
        .ERR_LIMIT   (4),
        .BLOCK_CYCLES(64)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus.slave),
        .clear_cnt         (clear_cnt),
        .acc_cnt           (acc_cnt),
        .drop_full_cnt     (drop_full_cnt),
        .drop_full_dest_cnt(drop_full_dest_cnt),
        .err_cnt           (err_cnt),
        .drop_blk_cnt      (drop_blk_cnt),
        .blocked           (blocked)
    );

    always #5 clk = ~clk;

    task automatic put(input logic v, input logic [PW-1:0] p);
        @(negedge clk);
        bus.valid_in = v;
        bus.pkt_in   = p;
    endtask

    task automatic do_clear;
        @(negedge clk);
        clear_cnt = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        clear_cnt     = 1'b0;
        bus.valid_in  = 1'b0;
        bus.pkt_in    = '0;
        bus.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.fifo_wr_en, blocked, bus.fifo_wr_data} !== '0)
            $display("FAIL reset_outs: got wr=%0b blk=%0b data=%h want 0",
                     bus.fifo_wr_en, blocked, bus.fifo_wr_data);
        else n_pass++;
        n_total++;
        if ({acc_cnt, drop_full_cnt, drop_full_dest_cnt,
             err_cnt, drop_blk_cnt} !== '0)
            $display("FAIL reset_cnts: got %h %h %h %h %h want all 0",
                     acc_cnt, drop_full_cnt, drop_full_dest_cnt,
                     err_cnt, drop_blk_cnt);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_accept;
        put(1'b1, 16'h0041);
        @(negedge clk);
        n_total++;
        if (bus.fifo_wr_en !== 1'b1)
            $display("FAIL acc_wr_en: got %0b want 1", bus.fifo_wr_en);
        else n_pass++;
        n_total++;
        if (bus.fifo_wr_data !== 16'h0041)
            $display("FAIL acc_wr_data: got %h want 0041", bus.fifo_wr_data);
        else n_pass++;
        bus.valid_in = 1'b0;
        bus.pkt_in   = 16'hFFFF;
        @(negedge clk);
        n_total++;
        if (bus.fifo_wr_data !== 16'h0000)
            $display("FAIL idle_wr_data: got %h want 0000", bus.fifo_wr_data);
        else n_pass++;
        n_total++;
        if (acc_cnt !== 4'd1)
            $display("FAIL acc_cnt: got %0d want 1", acc_cnt);
        else n_pass++;
        n_total++;
        if ({drop_full_cnt, drop_full_dest_cnt, err_cnt, drop_blk_cnt} !== '0)
            $display("FAIL acc_others: got %h %h %h %h want 0",
                     drop_full_cnt, drop_full_dest_cnt, err_cnt, drop_blk_cnt);
        else n_pass++;
        do_clear();
        n_total++;
        if (acc_cnt !== 4'd0)
            $display("FAIL clear_acc: got %0d want 0", acc_cnt);
        else n_pass++;
    endtask

    task automatic test_full;
        bus.pkt_in = '0;
        put(1'b1, 16'h00D1);
        bus.fifo_full = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.fifo_wr_en !== 1'b0)
            $display("FAIL full_wr_en: got %0b want 0", bus.fifo_wr_en);
        else n_pass++;
        bus.valid_in = 1'b0;
        @(negedge clk);
        n_total++;
        if (drop_full_cnt !== 4'd1 || drop_full_dest_cnt !== 4'd3)
            $display("FAIL full_one: got cnt=%0d dest=%0d want 1 3",
                     drop_full_cnt, drop_full_dest_cnt);
        else n_pass++;
        n_total++;
        if (acc_cnt !== 4'd0)
            $display("FAIL full_acc: got %0d want 0", acc_cnt);
        else n_pass++;
        for (int i = 0; i < 5; i++) put(1'b1, 16'h00D1);
        put(1'b0, 16'h0000);
        @(negedge clk);
        n_total++;
        if (drop_full_cnt !== 4'd6 || drop_full_dest_cnt !== 4'd15)
            $display("FAIL full_clamp: got cnt=%0d dest=%0d want 6 15",
                     drop_full_cnt, drop_full_dest_cnt);
        else n_pass++;
        bus.fifo_full = 1'b0;
        do_clear();
    endtask

    task automatic test_block;
        int cnt;
        for (int i = 0; i < 4; i++) put(1'b1, 16'h0042);
        put(1'b0, 16'h0000);
        n_total++;
        if (blocked !== 1'b0)
            $display("FAIL blk_early: got %0b want 0", blocked);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (blocked !== 1'b1 || err_cnt !== 4'd4)
            $display("FAIL blk_enter: got blk=%0b err=%0d want 1 4",
                     blocked, err_cnt);
        else n_pass++;
        cnt = 1;
        bus.valid_in = 1'b1;
        bus.pkt_in   = 16'h0041;
        @(negedge clk);
        n_total++;
        if (bus.fifo_wr_en !== 1'b0)
            $display("FAIL blk_wr_en: got %0b want 0", bus.fifo_wr_en);
        else n_pass++;
        bus.valid_in = 1'b0;
        if (blocked) cnt++;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!blocked) break;
            cnt++;
        end
        n_total++;
        if (cnt !== 64)
            $display("FAIL blk_len: got %0d cycles want 64", cnt);
        else n_pass++;
        n_total++;
        if (drop_blk_cnt !== 4'd1 || acc_cnt !== 4'd0 || err_cnt !== 4'd4)
            $display("FAIL blk_cnts: got blk=%0d acc=%0d err=%0d want 1 0 4",
                     drop_blk_cnt, acc_cnt, err_cnt);
        else n_pass++;
        bus.valid_in = 1'b1;
        bus.pkt_in   = 16'h0041;
        @(negedge clk);
        n_total++;
        if (bus.fifo_wr_en !== 1'b1)
            $display("FAIL post_blk_wr: got %0b want 1", bus.fifo_wr_en);
        else n_pass++;
        bus.valid_in = 1'b0;
        @(negedge clk);
        n_total++;
        if (acc_cnt !== 4'd1)
            $display("FAIL post_blk_acc: got %0d want 1", acc_cnt);
        else n_pass++;
        do_clear();
    endtask

    task automatic test_err_run;
        logic [PW-1:0] seq [0:5] = '{16'h0001, 16'h0021, 16'h0041,
                                     16'h0341, 16'h0042, 16'h0001};
        bit done;
        for (int i = 0; i < 6; i++) put(1'b1, seq[i]);
        put(1'b0, 16'h0000);
        @(negedge clk);
        n_total++;
        if (blocked !== 1'b0 || err_cnt !== 4'd5 || acc_cnt !== 4'd1)
            $display("FAIL err_run: got blk=%0b err=%0d acc=%0d want 0 5 1",
                     blocked, err_cnt, acc_cnt);
        else n_pass++;
        put(1'b1, 16'h0021);
        put(1'b0, 16'h0000);
        @(negedge clk);
        n_total++;
        if (blocked !== 1'b1)
            $display("FAIL err_run_4th: got blk=%0b want 1", blocked);
        else n_pass++;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!blocked) begin
                done = 1'b1;
                break;
            end
        end
        n_total++;
        if (done !== 1'b1 || err_cnt !== 4'd6)
            $display("FAIL err_run_exit: got done=%0b err=%0d want 1 6",
                     done, err_cnt);
        else n_pass++;
        do_clear();
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 17; i++) put(1'b1, 16'h0041);
        put(1'b0, 16'h0000);
        @(negedge clk);
        n_total++;
        if (acc_cnt !== 4'd15)
            $display("FAIL sat_acc: got %0d want 15", acc_cnt);
        else n_pass++;
        put(1'b1, 16'h0041);
        @(negedge clk);
        n_total++;
        if (bus.fifo_wr_en !== 1'b1)
            $display("FAIL clr_race_wr: got %0b want 1", bus.fifo_wr_en);
        else n_pass++;
        bus.valid_in = 1'b0;
        clear_cnt    = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
        n_total++;
        if (acc_cnt !== 4'd0)
            $display("FAIL clr_race_acc: got %0d want 0", acc_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) put(1'b1, 16'h0042);
        put(1'b0, 16'h0000);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.pkt_in   = 16'h0041;
        @(negedge clk);
        bus.valid_in = 1'b0;
        n_total++;
        if (blocked !== 1'b1 || bus.fifo_wr_data !== 16'h0041)
            $display("FAIL pre_rst: got blk=%0b data=%h want 1 0041",
                     blocked, bus.fifo_wr_data);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({blocked, bus.fifo_wr_en, bus.fifo_wr_data} !== '0)
            $display("FAIL rst_mid_outs: got blk=%0b wr=%0b data=%h want 0",
                     blocked, bus.fifo_wr_en, bus.fifo_wr_data);
        else n_pass++;
        n_total++;
        if ({acc_cnt, err_cnt, drop_blk_cnt} !== '0)
            $display("FAIL rst_mid_cnts: got acc=%0d err=%0d blk=%0d want 0",
                     acc_cnt, err_cnt, drop_blk_cnt);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (blocked !== 1'b0 || drop_blk_cnt !== 4'd0)
            $display("FAIL rst_rel: got blk=%0b dblk=%0d want 0 0",
                     blocked, drop_blk_cnt);
        else n_pass++;
        put(1'b1, 16'h0041);
        @(negedge clk);
        n_total++;
        if (bus.fifo_wr_en !== 1'b1)
            $display("FAIL rst_pass_wr: got %0b want 1", bus.fifo_wr_en);
        else n_pass++;
        bus.valid_in = 1'b0;
        @(negedge clk);
        n_total++;
        if (acc_cnt !== 4'd1)
            $display("FAIL rst_pass_acc: got %0d want 1", acc_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_accept();
        test_full();
        test_block();
        test_err_run();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
